// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg: opcode, ALUop and ALU2 encodings plus the
// FSM state, instruction class, branch kind and strobe types.
package ex_ctrl_pkg;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_NAND  = 4'b1000;
   localparam logic [3:0] OP_BZ    = 4'b0101;
   localparam logic [3:0] OP_BNZ   = 4'b1001;
   localparam logic [3:0] OP_BPZ   = 4'b1101;

   localparam logic [2:0] OP_SHIFT_LO3 = 3'b011;
   localparam logic [2:0] OP_ORI_LO3   = 3'b111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b010;
   localparam logic [2:0] ALU_NAND  = 3'b011;
   localparam logic [2:0] ALU_SHIFT = 3'b100;

   localparam logic [1:0] ALU2_REG   = 2'b00;
   localparam logic [1:0] ALU2_IMM   = 2'b10;
   localparam logic [1:0] ALU2_SHAMT = 2'b11;

   typedef enum logic {
      S_RUN,
      S_MEM
   } state_t;

   typedef enum logic [1:0] {
      CL_NONE,
      CL_ALU,
      CL_BR,
      CL_MEM
   } cls_t;

   typedef enum logic [1:0] {
      BR_Z,
      BR_NZ,
      BR_PZ
   } brk_t;

   typedef struct packed {
      logic flag_write;
      logic alu_out_write;
      logic ir4_load;
      logic mem_read;
      logic mem_write;
      logic mdr_load;
      logic branch_taken;
      logic ex_busy;
   } strb_t;

endpackage

// File: rtl/ex_control_pipe_if.sv
// ex_control_pipe_if: IR3/handshake/flag inputs and decoded strobes.
// master = upstream/environment side, slave = ex_control_pipe.
interface ex_control_pipe_if #(
   parameter int IW      = 8,
   parameter int ALUOP_W = 3
);
   logic [IW-1:0]      ir3;
   logic               ir3_valid;
   logic               stall_in;
   logic               flush;
   logic               mem_ready;
   logic               N;
   logic               Z;
   logic [ALUOP_W-1:0] ALUop;
   logic [1:0]         ALU2;
   logic               flag_write;
   logic               alu_out_write;
   logic               ir4_load;
   logic               mem_read;
   logic               mem_write;
   logic               mdr_load;
   logic               branch_taken;
   logic               ex_busy;
   logic               mem_error;

   modport master (
      output ir3, ir3_valid, stall_in, flush, mem_ready, N, Z,
      input  ALUop, ALU2, flag_write, alu_out_write, ir4_load,
      input  mem_read, mem_write, mdr_load, branch_taken,
      input  ex_busy, mem_error
   );

   modport slave (
      input  ir3, ir3_valid, stall_in, flush, mem_ready, N, Z,
      output ALUop, ALU2, flag_write, alu_out_write, ir4_load,
      output mem_read, mem_write, mdr_load, branch_taken,
      output ex_busy, mem_error
   );
endinterface

// File: rtl/ex_decode.sv
// ex_decode: combinational IR3 opcode decoder.
// i_op = ir3[3:0]; outputs class, ALUop, ALU2, branch kind, load/store.
module ex_decode
   import ex_ctrl_pkg::*;
(
   input  logic [3:0] i_op,
   output cls_t       o_cls,
   output logic [2:0] o_aluop,
   output logic [1:0] o_alu2,
   output brk_t       o_brk,
   output logic       o_is_load
);

   always_comb begin
      o_cls     = CL_NONE;
      o_aluop   = ALU_ADD;
      o_alu2    = ALU2_REG;
      o_brk     = BR_Z;
      o_is_load = 1'b0;
      unique case (1'b1)
         (i_op[2:0] == OP_SHIFT_LO3): begin
            o_cls   = CL_ALU;
            o_aluop = ALU_SHIFT;
            o_alu2  = ALU2_SHAMT;
         end
         (i_op[2:0] == OP_ORI_LO3): begin
            o_cls   = CL_ALU;
            o_aluop = ALU_OR;
            o_alu2  = ALU2_IMM;
         end
         (i_op == OP_ADD): begin
            o_cls   = CL_ALU;
            o_aluop = ALU_ADD;
         end
         (i_op == OP_SUB): begin
            o_cls   = CL_ALU;
            o_aluop = ALU_SUB;
         end
         (i_op == OP_NAND): begin
            o_cls   = CL_ALU;
            o_aluop = ALU_NAND;
         end
         (i_op == OP_LOAD): begin
            o_cls     = CL_MEM;
            o_is_load = 1'b1;
         end
         (i_op == OP_STORE): o_cls = CL_MEM;
         (i_op == OP_BZ): begin
            o_cls = CL_BR;
            o_brk = BR_Z;
         end
         (i_op == OP_BNZ): begin
            o_cls = CL_BR;
            o_brk = BR_NZ;
         end
         (i_op == OP_BPZ): begin
            o_cls = CL_BR;
            o_brk = BR_PZ;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_control_pipe.sv
// ex_control_pipe: EX-stage control FSM with registered strobes.
// clock/reset (async, active-low) plus bus (ex_control_pipe_if.slave).
module ex_control_pipe
   import ex_ctrl_pkg::*;
#(
   parameter int IW          = 8,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = $clog2(MEM_TIMEOUT)
) (
   input logic              clock,
   input logic              reset,
   ex_control_pipe_if.slave bus
);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_is_load, w_is_load_nxt;
   strb_t              r_strb, w_strb_nxt;
   logic [ALUOP_W-1:0] r_aluop, w_aluop_nxt;
   logic [1:0]         r_alu2, w_alu2_nxt;
   logic               r_mem_error, w_mem_error_nxt;

   logic [IW-1:0]      w_ir3;
   logic               w_unused_ir3;
   cls_t               w_cls;
   logic [2:0]         w_dec_aluop;
   logic [1:0]         w_dec_alu2;
   brk_t               w_brk;
   logic               w_dec_load;
   logic               w_issue;
   logic               w_timeout;
   logic               w_cond;

   // only ir3[3:0] carries the opcode
   assign w_ir3        = bus.ir3;
   assign w_unused_ir3 = ^w_ir3;

   ex_decode u_dec (
      .i_op      (w_ir3[3:0]),
      .o_cls     (w_cls),
      .o_aluop   (w_dec_aluop),
      .o_alu2    (w_dec_alu2),
      .o_brk     (w_brk),
      .o_is_load (w_dec_load)
   );

   assign w_issue = (r_state == S_RUN) && !bus.flush &&
                    !bus.stall_in && bus.ir3_valid;
   assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      unique case (w_brk)
         BR_NZ:   w_cond = !bus.Z;
         BR_PZ:   w_cond = !bus.N;
         default: w_cond = bus.Z;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_RUN;
         r_cnt     <= '0;
         r_is_load <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_is_load <= w_is_load_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_is_load_nxt = r_is_load;
      unique case (r_state)
         S_RUN: begin
            if (w_issue && (w_cls == CL_MEM)) begin
               w_state_nxt   = S_MEM;
               w_cnt_nxt     = '0;
               w_is_load_nxt = w_dec_load;
            end
         end
         S_MEM: begin
            if (bus.flush || bus.mem_ready || w_timeout)
               w_state_nxt = S_RUN;
            else
               w_cnt_nxt = r_cnt + 1'b1;
         end
      endcase
   end

   always_comb begin
      w_strb_nxt      = '0;
      w_aluop_nxt     = r_aluop;
      w_alu2_nxt      = r_alu2;
      w_mem_error_nxt = r_mem_error;
      unique case (r_state)
         S_RUN: begin
            if (w_issue) begin
               unique case (w_cls)
                  CL_ALU: begin
                     w_strb_nxt.flag_write    = 1'b1;
                     w_strb_nxt.alu_out_write = 1'b1;
                     w_strb_nxt.ir4_load      = 1'b1;
                     w_aluop_nxt = ALUOP_W'(w_dec_aluop);
                     w_alu2_nxt  = w_dec_alu2;
                  end
                  CL_BR: begin
                     w_strb_nxt.ir4_load     = 1'b1;
                     w_strb_nxt.branch_taken = w_cond;
                  end
                  CL_MEM: begin
                     w_strb_nxt.mem_read  = w_dec_load;
                     w_strb_nxt.mem_write = !w_dec_load;
                     w_strb_nxt.ex_busy   = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_MEM: begin
            // flush leaves everything at zero
            if (!bus.flush) begin
               if (bus.mem_ready) begin
                  w_strb_nxt.ir4_load = 1'b1;
                  w_strb_nxt.mdr_load = r_is_load;
               end else if (w_timeout) begin
                  // aborted access retires as a bubble
                  w_strb_nxt.ir4_load = 1'b1;
                  w_mem_error_nxt     = 1'b1;
               end else begin
                  w_strb_nxt.mem_read  = r_is_load;
                  w_strb_nxt.mem_write = !r_is_load;
                  w_strb_nxt.ex_busy   = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_strb      <= '0;
         r_aluop     <= '0;
         r_alu2      <= '0;
         r_mem_error <= 1'b0;
      end else begin
         r_strb      <= w_strb_nxt;
         r_aluop     <= w_aluop_nxt;
         r_alu2      <= w_alu2_nxt;
         r_mem_error <= w_mem_error_nxt;
      end
   end

   assign bus.ALUop         = r_aluop;
   assign bus.ALU2          = r_alu2;
   assign bus.flag_write    = r_strb.flag_write;
   assign bus.alu_out_write = r_strb.alu_out_write;
   assign bus.ir4_load      = r_strb.ir4_load;
   assign bus.mem_read      = r_strb.mem_read;
   assign bus.mem_write     = r_strb.mem_write;
   assign bus.mdr_load      = r_strb.mdr_load;
   assign bus.branch_taken  = r_strb.branch_taken;
   assign bus.ex_busy       = r_strb.ex_busy;
   assign bus.mem_error     = r_mem_error;

endmodule

// File: doc/ex_control_pipe.md
# ex_control_pipe

Parametrised execute-stage control unit for the 8-bit pipelined processor. It sits between the IR3 register and the ALU / data-memory / IR4 logic. It decodes the instruction in IR3 into registered ALU, flag, memory and writeback strobes. Beyond the single-cycle decoder it replaces, it adds:
- a valid/stall/flush pipeline handshake;
- a multi-cycle memory handshake with a timeout;
- branch-condition evaluation.

## Interface
Parameters:
- IW, 8, instruction width; the opcode is always ir3[3:0], so IW ≥ 4.
- ALUOP_W, 3, width of ALUop.
- MEM_TIMEOUT, 16, cycles waited for mem_ready before a memory op is aborted; ≥ 2.
- CNT_W, $clog2(MEM_TIMEOUT), timeout counter width.

Ports (clock and reset first):
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low.
- ir3  in  IW  instruction in the EX stage.
- ir3_valid  in  1  ir3 holds a real instruction.
- stall_in  in  1  downstream cannot accept; do not issue.
- flush  in  1  kill the current/pending instruction.
- mem_ready  in  1  data memory completes the access this cycle.
- N, Z  in  1 each  condition flags.
- ALUop  out  ALUOP_W  ALU function.
- ALU2  out  2  ALU B-operand select.
- flag_write, alu_out_write, ir4_load  out  1 each  writeback strobes.
- mem_read, mem_write, mdr_load  out  1 each  memory strobes.
- branch_taken  out  1  the resolved branch is taken.
- ex_busy  out  1  a memory op is in flight; upstream must hold IR3.
- mem_error  out  1  sticky; set when a timeout occurred.

## Operation
Decode table (other opcodes are bubbles). The ALU ops are single-cycle; ALU2=00 unless listed.

| Instruction | Match | ALUop | ALU2 |
|---|---|---|---|
| shift | ir3[2:0]=011 | 100 | 11 |
| ori | ir3[2:0]=111 | 010 | 10 |
| add | ir3[3:0]=0100 | 000 | 00 |
| sub | ir3[3:0]=0110 | 001 | 00 |
| nand | ir3[3:0]=1000 | 011 | 00 |
| load | ir3[3:0]=0000 | — | — |
| store | ir3[3:0]=0010 | — | — |
| bz | ir3[3:0]=0101 | — | — |
| bnz | ir3[3:0]=1001 | — | — |
| bpz | ir3[3:0]=1101 | — | — |

- ALU ops (shift, ori, add, sub, nand) assert flag_write=1, alu_out_write=1 and ir4_load=1.
- Branches evaluate bz=Z, bnz=!Z, bpz=!N, using N/Z sampled at the issue edge.
- A branch asserts ir4_load=1; branch_taken is the condition result.

FSM states:
- **RUN**
  - Priority: flush > stall_in > issue.
  - flush: all strobes 0.
  - stall_in: all strobes 0; ALUop/ALU2 hold.
  - Issue when ir3_valid=1 and stall_in=0:
    - ALU/branch: strobes as decoded.
    - load/store: latch the type, assert mem_read or mem_write, ir4_load=0, ex_busy=1, counter←0, go to MEM.
    - Unknown opcode or ir3_valid=0: bubble (all strobes 0).
- **MEM**
  - The request strobe stays high until completion or abort.
  - flush → abort: strobes 0, ex_busy=0, go to RUN.
  - Else mem_ready=1 → request strobe 0, ir4_load=1, mdr_load=1 (load only), ex_busy=0, go to RUN.
  - Else counter=MEM_TIMEOUT-1 → request strobe 0, mem_error←1, ir4_load=1 (retire as a bubble, mdr_load=0), go to RUN.
  - Else counter+1. stall_in and ir3 are ignored in MEM.
- Non-strobe outputs:
  - branch_taken is 0 except in the cycle after a branch issues.
  - mem_error is cleared only by reset.

## Timing
- All outputs are registered. A decision made at edge k is visible in cycle k..k+1 (1-cycle latency from ir3 sampling).
- Single-pulse strobes (flag_write, alu_out_write, ir4_load, mdr_load, branch_taken) last one cycle per instruction. Back-to-back ALU ops produce continuous strobes.
- Memory latency = (cycles until mem_ready) + 1.
  - mem_ready high on the first MEM cycle gives mem_read for 1 cycle, then ir4_load+mdr_load in the next cycle.
  - An abort on timeout drops the request after MEM_TIMEOUT cycles of request.
- mem_ready seen in RUN is ignored.
- Reset (asynchronous assert, at any time including mid-MEM):
  - state=RUN, counter=0;
  - every output 0, including ALUop=0, ALU2=00 and mem_error=0.
- Reset release is synchronous-safe: the first issue is on the first rising edge after deassertion.

## Structure
- Shared package ex_ctrl_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND, OP_BZ, OP_BNZ, OP_BPZ, OP_SHIFT_LO3, OP_ORI_LO3);
  - ALUop encodings (ALU_ADD=000, ALU_SUB=001, ALU_OR=010, ALU_NAND=011, ALU_SHIFT=100);
  - ALU2 selects;
  - the FSM state enum.
- Sub-module ex_decode: purely combinational. Maps ir3 to an ALU/branch/mem class plus ALUop/ALU2 and the branch kind. The FSM and output registers live in ex_control_pipe.

## Test plan
- Reset mid-MEM (mem_read=1, counter=5): assert reset low → all outputs 0 immediately. After release, add 8'h14 issues normally.
- Sequence add 8'h14, sub 8'h16, nand 8'h28, ori 8'h07, shift 8'h03 with ir3_valid=1 → the following 5 cycles show ALUop 000/001/011/010/100, ALU2 00/00/00/10/11, and flag_write=alu_out_write=ir4_load=1 each cycle.
- Load 8'h00 with mem_ready rising 3 cycles after issue:
  - mem_read=1 and ex_busy=1 for 3 cycles;
  - then mem_read=0, mdr_load=1, ir4_load=1 for 1 cycle.
- Store 8'h02 with mem_ready stuck low (MEM_TIMEOUT=16):
  - mem_write=1 for 16 cycles;
  - then mem_error=1 (sticky), ir4_load=1, mdr_load=0, ex_busy=0.
- Branches: bz with Z=1 → branch_taken=1; bnz with Z=1 → 0; bpz with N=1 → 0; ir4_load=1 in each case. Unknown opcode 8'h0A → all strobes 0.
- Priority:
  - flush together with ir3_valid=1 (add) → strobes 0;
  - stall_in=1 with add → no strobes and ALUop held;
  - flush during MEM → request dropped next cycle, no mdr_load, mem_error unchanged.
